gba_sound_bus_master: RTL and testbench

Initiator side of the GBA sound MMIO bus. Accepts single CPU/DMA register accesses on a valid/ready request port and converts each into one `gb_bus` transaction (one-cycle `gb_bus_ena` strobe) toward the sound channel and sound-control responders. For reads it captures the responders' registered `gb_bus_dout` and returns it right-aligned. After reset it issues the `gb_bus_rst` pulse that initialises all responder registers.

---
 rtl/gba_sound_bus_master.sv | 194 +++++++++++++++++++
 tb/tb_gba_sound_bus_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gba_sound_bus_master.sv
// gba_sound_bus_master
//   Initiator side of the GBA sound MMIO bus. Turns one accepted CPU/DMA
//   register access into a single gb_bus transaction (one-cycle ena strobe),
//   captures read data from the responders and returns it right-aligned.
//   After reset, gb_bus_rst is held for RST_CYCLES cycles to initialise
//   every responder register.
//
// Ports
//   clk, reset           : system clock, synchronous active-high reset
//   cpu_req/cpu_ready    : request handshake (accept on req & ready)
//   cpu_adr/rnw/size     : byte address, direction, size (0 B, 1 H, 2/3 W)
//   cpu_wdata            : right-aligned write data
//   cpu_rvalid/cpu_rdata : one-cycle completion pulse, zero-extended read data
//   gb_bus_adr/din/dout  : word-aligned address, lane-steered write data, read data
//   gb_bus_rnw/ena/acc/be: direction, strobe, issued size, byte enables
//   gb_bus_rst           : responder register reset
//   gb_bus_done          : one-cycle pulse when the bus transaction retires
//
// state  | meaning
// INIT   | gb_bus_rst asserted, down-counter running, no requests taken
// IDLE   | cpu_ready high, waiting for a request
// ISSUE  | gb_bus_ena strobe; writes retire here
// WAIT   | read only: responder drives dout, sampled at end of cycle
// RESP   | cpu_rvalid pulse toward the requester
module gba_sound_bus_master #(
  parameter int ADR_W      = 28,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  output logic             cpu_ready,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic             cpu_rnw,
  input  logic [1:0]       cpu_size,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_rvalid,
  output logic [31:0]      cpu_rdata,
  output logic [ADR_W-1:0] gb_bus_adr,
  output logic [31:0]      gb_bus_din,
  input  logic [31:0]      gb_bus_dout,
  output logic             gb_bus_rnw,
  output logic             gb_bus_ena,
  output logic [1:0]       gb_bus_acc,
  output logic [3:0]       gb_bus_be,
  output logic             gb_bus_rst,
  output logic             gb_bus_done
);

  localparam int               CNT_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rnw_q, rnw_d;
  logic [1:0]       acc_q, acc_d;
  logic [1:0]       lane_q, lane_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [31:0]      din_q, din_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [1:0]       req_acc;
  logic [1:0]       req_lane;
  logic [31:0]      req_din;
  logic [31:0]      dout_shift;
  logic             issue;

  // Request decode: size 3 folds into word, lane bits are forced to the
  // natural alignment of the access, write data is replicated across lanes.
  always_comb begin
    req_acc  = (cpu_size == 2'd3) ? 2'd2 : cpu_size;
    req_lane = cpu_adr[1:0];
    req_din  = cpu_wdata;
    case (req_acc)
      2'd0: req_din = {4{cpu_wdata[7:0]}};
      2'd1: begin
        req_lane = {cpu_adr[1], 1'b0};
        req_din  = {2{cpu_wdata[15:0]}};
      end
      default: req_lane = 2'b00;
    endcase
  end

  // Halfword lanes are always 0 or 2, so a byte-granular shift covers both sizes.
  assign dout_shift = gb_bus_dout >> {lane_q, 3'b000};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rnw_d       = rnw_q;
    acc_d       = acc_q;
    lane_d      = lane_q;
    adr_d       = adr_q;
    din_d       = din_q;
    rdata_d     = rdata_q;
    cpu_ready   = 1'b0;
    cpu_rvalid  = 1'b0;
    gb_bus_ena  = 1'b0;
    gb_bus_done = 1'b0;
    gb_bus_rst  = 1'b0;
    case (state_q)
      S_INIT: begin
        gb_bus_rst = 1'b1;
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req) begin
          rnw_d   = cpu_rnw;
          acc_d   = req_acc;
          lane_d  = req_lane;
          adr_d   = {cpu_adr[ADR_W-1:2], 2'b00};
          din_d   = req_din;
          rdata_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        gb_bus_ena = 1'b1;
        if (rnw_q) begin
          state_d = S_WAIT;
        end else begin
          // a reset landing now aborts the write, so it must not report done
          gb_bus_done = ~reset;
          state_d     = S_RESP;
        end
      end
      S_WAIT: begin
        gb_bus_done = ~reset;
        case (acc_q)
          2'd0:    rdata_d = {24'h0, dout_shift[7:0]};
          2'd1:    rdata_d = {16'h0, dout_shift[15:0]};
          default: rdata_d = gb_bus_dout;
        endcase
        state_d = S_RESP;
      end
      S_RESP: begin
        cpu_rvalid = ~reset;
        state_d    = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= CNT_LOAD;
      rnw_q   <= 1'b0;
      acc_q   <= 2'd0;
      lane_q  <= 2'd0;
      adr_q   <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rnw_q   <= rnw_d;
      acc_q   <= acc_d;
      lane_q  <= lane_d;
      adr_q   <= adr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
    end
  end

  assign issue      = (state_q == S_ISSUE);
  assign gb_bus_adr = adr_q;
  assign gb_bus_din = din_q;
  assign gb_bus_rnw = issue & rnw_q;
  assign gb_bus_acc = issue ? acc_q : 2'd0;
  assign cpu_rdata  = (state_q == S_RESP) ? rdata_q : 32'h0;

  always_comb begin
    gb_bus_be = 4'b0000;
    if (issue) begin
      case (acc_q)
        2'd0:    gb_bus_be = 4'b0001 << lane_q;
        2'd1:    gb_bus_be = lane_q[1] ? 4'b1100 : 4'b0011;
        default: gb_bus_be = 4'b1111;
      endcase
    end
  end

endmodule

// File: tb/tb_gba_sound_bus_master.sv
module tb_gba_sound_bus_master;

  localparam int ADR_W      = 28;
  localparam int RST_CYCLES = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             cpu_req;
  logic             cpu_ready;
  logic [ADR_W-1:0] cpu_adr;
  logic             cpu_rnw;
  logic [1:0]       cpu_size;
  logic [31:0]      cpu_wdata;
  logic             cpu_rvalid;
  logic [31:0]      cpu_rdata;
  logic [ADR_W-1:0] gb_bus_adr;
  logic [31:0]      gb_bus_din;
  logic [31:0]      gb_bus_dout;
  logic             gb_bus_rnw;
  logic             gb_bus_ena;
  logic [1:0]       gb_bus_acc;
  logic [3:0]       gb_bus_be;
  logic             gb_bus_rst;
  logic             gb_bus_done;

  int checks   = 0;
  int failures = 0;

  gba_sound_bus_master #(.ADR_W(ADR_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_ready   (cpu_ready),
    .cpu_adr     (cpu_adr),
    .cpu_rnw     (cpu_rnw),
    .cpu_size    (cpu_size),
    .cpu_wdata   (cpu_wdata),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .gb_bus_adr  (gb_bus_adr),
    .gb_bus_din  (gb_bus_din),
    .gb_bus_dout (gb_bus_dout),
    .gb_bus_rnw  (gb_bus_rnw),
    .gb_bus_ena  (gb_bus_ena),
    .gb_bus_acc  (gb_bus_acc),
    .gb_bus_be   (gb_bus_be),
    .gb_bus_rst  (gb_bus_rst),
    .gb_bus_done (gb_bus_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: access rules expressed as plain arithmetic.
  function automatic int eff_size(input logic [1:0] s);
    return (s == 2'd3) ? 2 : int'(s);
  endfunction

  function automatic logic [31:0] exp_be(input logic [ADR_W-1:0] a, input logic [1:0] s);
    int off = int'(a % 4);
    case (eff_size(s))
      0:       return 32'h1 << off;
      1:       return ((off / 2) == 1) ? 32'hC : 32'h3;
      default: return 32'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_din(input logic [31:0] w, input logic [1:0] s);
    case (eff_size(s))
      0:       return (w & 32'hFF) * 32'h01010101;
      1:       return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [ADR_W-1:0] a, input logic [1:0] s,
                                            input logic [31:0] d);
    int off = int'(a % 4);
    case (eff_size(s))
      0:       return (d >> (8 * off)) & 32'hFF;
      1:       return (d >> (16 * (off / 2))) & 32'hFFFF;
      default: return d;
    endcase
  endfunction

  // Entered and left at the sample point (#2 after posedge) of an IDLE cycle.
  task automatic do_access(input string tag, input logic [ADR_W-1:0] adr, input logic rnw,
                           input logic [1:0] size, input logic [31:0] wdata,
                           input logic driven, input logic [31:0] resp);
    int          waited = 0;
    logic [31:0] bus_data;
    cpu_req   = 1'b1;
    cpu_adr   = adr;
    cpu_rnw   = rnw;
    cpu_size  = size;
    cpu_wdata = wdata;
    while (!cpu_ready && waited < 16) begin
      @(posedge clk); #2;
      waited++;
    end
    check({tag, ".accept"}, 32'(cpu_ready), 32'h1);
    // T+1: strobe cycle; scramble the request inputs to prove they were latched
    @(posedge clk); #1;
    cpu_req   = 1'b0;
    cpu_adr   = ADR_W'($urandom);
    cpu_wdata = $urandom;
    cpu_rnw   = ~rnw;
    cpu_size  = 2'($urandom);
    #1;
    check({tag, ".ena"},   32'(gb_bus_ena), 32'h1);
    check({tag, ".adr"},   32'(gb_bus_adr), 32'(adr) & ~32'h3);
    check({tag, ".be"},    32'(gb_bus_be), exp_be(adr, size));
    check({tag, ".rnw"},   32'(gb_bus_rnw), 32'(rnw));
    check({tag, ".acc"},   32'(gb_bus_acc), 32'(eff_size(size)));
    check({tag, ".done1"}, 32'(gb_bus_done), rnw ? 32'h0 : 32'h1);
    check({tag, ".rdy1"},  32'(cpu_ready), 32'h0);
    if (!rnw) check({tag, ".din"}, gb_bus_din, exp_din(wdata, size));
    // T+2
    bus_data = (rnw && driven) ? resp : 32'h0;
    @(posedge clk); #1;
    gb_bus_dout = bus_data;
    #1;
    check({tag, ".ena2"},  32'(gb_bus_ena), 32'h0);
    check({tag, ".be2"},   32'(gb_bus_be), 32'h0);
    check({tag, ".acc2"},  32'(gb_bus_acc), 32'h0);
    check({tag, ".adr2"},  32'(gb_bus_adr), 32'(adr) & ~32'h3);
    if (rnw) begin
      check({tag, ".done2"},   32'(gb_bus_done), 32'h1);
      check({tag, ".rvalid2"}, 32'(cpu_rvalid), 32'h0);
    end else begin
      check({tag, ".done2"},   32'(gb_bus_done), 32'h0);
      check({tag, ".rvalid2"}, 32'(cpu_rvalid), 32'h1);
      check({tag, ".rdata2"},  cpu_rdata, 32'h0);
      check({tag, ".din2"},    gb_bus_din, exp_din(wdata, size));
    end
    // T+3
    @(posedge clk); #1;
    gb_bus_dout = 32'h0;
    #1;
    if (rnw) begin
      check({tag, ".rvalid3"}, 32'(cpu_rvalid), 32'h1);
      check({tag, ".rdata3"},  cpu_rdata, exp_rdata(adr, size, bus_data));
      check({tag, ".done3"},   32'(gb_bus_done), 32'h0);
      @(posedge clk); #2;
    end
    check({tag, ".rdy_end"},    32'(cpu_ready), 32'h1);
    check({tag, ".rvalid_end"}, 32'(cpu_rvalid), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  m_acc, m_ena, m_done, m_rvalid, m_rst;
    logic [31:0] rd_seen;
    int          acc_cycle2;

    reset       = 1'b1;
    cpu_req     = 1'b0;
    cpu_adr     = '0;
    cpu_rnw     = 1'b0;
    cpu_size    = 2'd0;
    cpu_wdata   = 32'h0;
    gb_bus_dout = 32'h0;

    // Reset sequence: 3 cycles high, then low.
    @(posedge clk); #2;
    check("rst.ready",  32'(cpu_ready),   32'h0);
    check("rst.rvalid", 32'(cpu_rvalid),  32'h0);
    check("rst.ena",    32'(gb_bus_ena),  32'h0);
    check("rst.rnw",    32'(gb_bus_rnw),  32'h0);
    check("rst.done",   32'(gb_bus_done), 32'h0);
    check("rst.rdata",  cpu_rdata,        32'h0);
    check("rst.adr",    32'(gb_bus_adr),  32'h0);
    check("rst.din",    gb_bus_din,       32'h0);
    check("rst.be",     32'(gb_bus_be),   32'h0);
    check("rst.acc",    32'(gb_bus_acc),  32'h0);
    check("rst.bus_rst",32'(gb_bus_rst),  32'h1);
    @(posedge clk); #2;
    check("rst.hold", 32'(gb_bus_rst), 32'h1);
    @(posedge clk); #2;
    check("rst.hold3", 32'(gb_bus_rst), 32'h1);
    // reset drops; a request in this very cycle must not be taken
    @(posedge clk); #1;
    reset   = 1'b0;
    cpu_req = 1'b1;
    #1;
    check("init1.bus_rst", 32'(gb_bus_rst), 32'h1);
    check("init1.ready",   32'(cpu_ready),  32'h0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    #1;
    check("init2.bus_rst", 32'(gb_bus_rst), 32'h1);
    check("init2.ready",   32'(cpu_ready),  32'h0);
    check("init2.ena",     32'(gb_bus_ena), 32'h0);
    @(posedge clk); #2;
    check("idle.bus_rst", 32'(gb_bus_rst), 32'h0);
    check("idle.ready",   32'(cpu_ready),  32'h1);
    check("idle.ena",     32'(gb_bus_ena), 32'h0);

    // Directed accesses.
    do_access("word_wr",  28'h4000090, 1'b0, 2'd2, 32'h12345678, 1'b0, 32'h0);
    do_access("byte_wr",  28'h4000073, 1'b0, 2'd0, 32'h000000A5, 1'b0, 32'h0);
    do_access("half_rd",  28'h4000076, 1'b1, 2'd1, 32'h0,        1'b1, 32'hBEEF0000);
    do_access("unmap_rd", 28'h4000081, 1'b1, 2'd0, 32'h0,        1'b0, 32'hDEADBEEF);

    // Randomized accesses with idle gaps.
    for (int n = 0; n < 40; n++) begin
      int gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #2;
        check("gap.ena",   32'(gb_bus_ena), 32'h0);
        check("gap.ready", 32'(cpu_ready),  32'h1);
      end
      do_access("rand", ADR_W'($urandom), 1'($urandom), 2'($urandom), $urandom,
                1'($urandom_range(0, 3) != 0), $urandom);
    end

    // Back-to-back with request held high, reset during the write's strobe.
    m_acc = '0; m_ena = '0; m_done = '0; m_rvalid = '0; m_rst = '0;
    rd_seen    = 32'h0;
    acc_cycle2 = -1;
    cpu_req    = 1'b1;
    cpu_rnw    = 1'b1;
    cpu_size   = 2'd0;
    cpu_adr    = 28'h4000062;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        reset       = (c == 5);
        gb_bus_dout = (c == 2) ? 32'h00C30000 : 32'h0;
        cpu_rnw     = 1'b0;
        cpu_size    = 2'd2;
        cpu_wdata   = 32'hCAFEF00D;
        cpu_adr     = 28'h4000084;
        #1;
      end
      m_acc[c]    = cpu_req & cpu_ready;
      m_ena[c]    = gb_bus_ena;
      m_done[c]   = gb_bus_done;
      m_rvalid[c] = cpu_rvalid;
      m_rst[c]    = gb_bus_rst;
      if (c == 3) rd_seen = cpu_rdata;
      if (c == 4) check("b2b.wr_rnw_ok", 32'(cpu_rnw), 32'h0);
      if (c == 5) check("b2b.wr_din", gb_bus_din, 32'hCAFEF00D);
      if (c > 0 && m_acc[c] && acc_cycle2 < 0) acc_cycle2 = c;
    end
    check("b2b.accepts", 32'(m_acc),    32'h11);
    check("b2b.acc2_at", 32'(acc_cycle2), 32'h4);
    check("b2b.ena",     32'(m_ena),    32'h22);
    check("b2b.done",    32'(m_done),   32'h04);
    check("b2b.rvalid",  32'(m_rvalid), 32'h08);
    check("b2b.bus_rst", 32'(m_rst),    32'hC0);
    check("b2b.rdata",   rd_seen,       32'h000000C3);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    reset   = 1'b0;
    #1;
    check("b2b.ready_after", 32'(cpu_ready),  32'h1);
    check("b2b.rst_after",   32'(gb_bus_rst), 32'h0);
    check("b2b.rvalid_after",32'(cpu_rvalid), 32'h0);

    // A clean access after the abort still works.
    do_access("post_abort", 28'h4000088, 1'b1, 2'd2, 32'h0, 1'b1, 32'h89ABCDEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
